// File: rtl/config_pkg.sv
// Core-wide configuration: user-facing knobs, derived config and shared constants.
// The instruction buffer takes its decode width and depth defaults from here.
package config_pkg;

    localparam int unsigned INSTR_BYTES = 4;

    typedef struct packed {
        int unsigned INSTR_PER_FETCH;
        int unsigned ILEN;
        int unsigned VLEN;
        int unsigned DECODE_WIDTH;
        int unsigned IBUF_DEPTH;
    } user_cfg_t;

    typedef struct packed {
        int unsigned INSTR_PER_FETCH;
        int unsigned ILEN;
        int unsigned VLEN;
        int unsigned DECODE_WIDTH;
        int unsigned IBUF_DEPTH;
        int unsigned FETCH_WIDTH;
    } cfg_t;

    function automatic cfg_t build_config(input user_cfg_t u);
        cfg_t c;
        c.INSTR_PER_FETCH = u.INSTR_PER_FETCH;
        c.ILEN            = u.ILEN;
        c.VLEN            = u.VLEN;
        c.DECODE_WIDTH    = u.DECODE_WIDTH;
        c.IBUF_DEPTH      = u.IBUF_DEPTH;
        c.FETCH_WIDTH     = u.INSTR_PER_FETCH * u.ILEN;
        return c;
    endfunction

    localparam user_cfg_t EmptyUserCfg = '{
        INSTR_PER_FETCH: 4,
        ILEN:            32,
        VLEN:            32,
        DECODE_WIDTH:    4,
        IBUF_DEPTH:      16
    };

    localparam cfg_t EmptyCfg = build_config(EmptyUserCfg);

endpackage

// File: rtl/lead_ones_cnt.sv
// Counts the run of ones starting at bit 0 of a mask and flags whether the mask
// is a single contiguous run (all ones above the run would be a protocol error).
module lead_ones_cnt #(
    parameter int unsigned WIDTH = 4
) (
    input  logic [WIDTH-1:0]             mask,
    output logic [$clog2(WIDTH+1)-1:0]   count,
    output logic                         contiguous
);

    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    logic run;

    always_comb begin
        count      = '0;
        contiguous = 1'b1;
        run        = 1'b1;
        for (int i = 0; i < WIDTH; i++) begin
            if (mask[i]) begin
                if (run) begin
                    count = CNT_W'(i + 1);
                end else begin
                    contiguous = 1'b0;
                end
            end else begin
                run = 1'b0;
            end
        end
    end

endmodule

// File: rtl/instr_buffer.sv
// Fetch-to-decode decoupling FIFO: one fetch group in, up to DECODE_WIDTH oldest
// instructions out, cleared on redirect. Perf counters built only with INSTR_BUFFER_PERF_EN.
module instr_buffer
    import config_pkg::*;
#(
    parameter config_pkg::cfg_t Cfg          = config_pkg::EmptyCfg,
    parameter int unsigned      DECODE_WIDTH = Cfg.DECODE_WIDTH,
    parameter int unsigned      DEPTH        = Cfg.IBUF_DEPTH
) (
    input  logic                                    clk_i,
    input  logic                                    rst_ni,
    input  logic                                    flush_i,
    input  logic                                    fe_valid_i,
    output logic                                    fe_ready_o,
    input  logic [Cfg.VLEN-1:0]                     fe_pc_i,
    input  logic [Cfg.INSTR_PER_FETCH*Cfg.ILEN-1:0] fe_instrs_i,
    input  logic [Cfg.INSTR_PER_FETCH-1:0]          fe_slot_valid_i,
    output logic [DECODE_WIDTH-1:0]                 de_valid_o,
    output logic [DECODE_WIDTH*Cfg.ILEN-1:0]        de_instrs_o,
    output logic [DECODE_WIDTH*Cfg.VLEN-1:0]        de_pc_o,
    input  logic                                    de_ready_i,
    output logic [31:0]                             perf_full_stall_o,
    output logic [31:0]                             perf_empty_cyc_o
);

    localparam int unsigned IPF    = Cfg.INSTR_PER_FETCH;
    localparam int unsigned ILEN   = Cfg.ILEN;
    localparam int unsigned VLEN   = Cfg.VLEN;
    localparam int unsigned PTR_W  = $clog2(DEPTH);
    localparam int unsigned CNT_W  = $clog2(DEPTH + 1);
    localparam int unsigned NENQ_W = $clog2(IPF + 1);

    typedef struct packed {
        logic [ILEN-1:0] instr;
        logic [VLEN-1:0] pc;
    } entry_t;

    entry_t            mem [DEPTH];
    logic [PTR_W-1:0]  head_q;
    logic [PTR_W-1:0]  tail_q;
    logic [CNT_W-1:0]  count_q;

    logic [NENQ_W-1:0] n_lead;
    logic [NENQ_W-1:0] n_enq;
    logic              mask_contig;
    logic [CNT_W-1:0]  n_pres;
    logic [CNT_W-1:0]  n_deq;
    logic              enq_fire;
    logic              deq_fire;

    lead_ones_cnt #(
        .WIDTH (IPF)
    ) u_lead_ones (
        .mask       (fe_slot_valid_i),
        .count      (n_lead),
        .contiguous (mask_contig)
    );

    // Handshakes: a transfer happens on a side only in a cycle where its valid and
    // ready are both high and flush_i is low. fe_ready_o depends on registered count
    // only; decode takes every presented lane or none.
    assign fe_ready_o = (count_q <= CNT_W'(DEPTH - IPF));
    assign enq_fire   = fe_valid_i & fe_ready_o & ~flush_i;
    assign n_enq      = enq_fire ? n_lead : '0;

    assign n_pres   = (count_q < CNT_W'(DECODE_WIDTH)) ? count_q : CNT_W'(DECODE_WIDTH);
    assign deq_fire = de_ready_i & (n_pres != '0) & ~flush_i;
    assign n_deq    = deq_fire ? n_pres : '0;

    // Payload storage carries no reset; only pointers and count define validity.
    always_ff @(posedge clk_i) begin
        for (int k = 0; k < IPF; k++) begin
            if (NENQ_W'(k) < n_enq) begin
                mem[tail_q + PTR_W'(k)] <= '{
                    instr: fe_instrs_i[k*ILEN +: ILEN],
                    pc:    fe_pc_i + VLEN'(INSTR_BYTES * k)
                };
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else if (flush_i) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_q + PTR_W'(n_deq);
            tail_q  <= tail_q + PTR_W'(n_enq);
            count_q <= count_q + CNT_W'(n_enq) - n_deq;
        end
    end

    for (genvar k = 0; k < DECODE_WIDTH; k++) begin : g_lane
        entry_t rd;
        assign rd            = mem[head_q + PTR_W'(k)];
        assign de_valid_o[k] = (CNT_W'(k) < n_pres) & ~flush_i;
        assign de_instrs_o[k*ILEN +: ILEN] = de_valid_o[k] ? rd.instr : '0;
        assign de_pc_o[k*VLEN +: VLEN]     = de_valid_o[k] ? rd.pc    : '0;
    end

`ifdef INSTR_BUFFER_PERF_EN
    logic [31:0] full_stall_q;
    logic [31:0] empty_cyc_q;

    // Saturating; flush deliberately leaves the history intact.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            full_stall_q <= '0;
            empty_cyc_q  <= '0;
        end else begin
            if (fe_valid_i && !fe_ready_o && !flush_i && (full_stall_q != '1)) begin
                full_stall_q <= full_stall_q + 32'd1;
            end
            if ((count_q == '0) && (empty_cyc_q != '1)) begin
                empty_cyc_q <= empty_cyc_q + 32'd1;
            end
        end
    end

    assign perf_full_stall_o = full_stall_q;
    assign perf_empty_cyc_o  = empty_cyc_q;
`else
    assign perf_full_stall_o = '0;
    assign perf_empty_cyc_o  = '0;
`endif

`ifndef SYNTHESIS
    a_mask_contig: assert property (@(posedge clk_i) disable iff (!rst_ni)
        enq_fire |-> mask_contig);
    a_count_bound: assert property (@(posedge clk_i) disable iff (!rst_ni)
        count_q <= CNT_W'(DEPTH));
`endif

endmodule

// File: doc/instr_buffer.md
Name: instr_buffer

Overview:
- Decoupling FIFO between ICache/fetch and decode.
- Accepts one fetch group per cycle: up to INSTR_PER_FETCH instructions, contiguous, starting at lane 0.
- Presents up to DECODE_WIDTH oldest instructions, each with its PC, to decode.
- Absorbs ICache-miss bubbles and decode back-pressure; flushed on redirect.

Parameters:
- Cfg, EmptyCfg, config_pkg::cfg_t. Uses INSTR_PER_FETCH, ILEN, VLEN.
- DECODE_WIDTH, 4, instructions presented to decode per cycle.
- DEPTH, 16, entry count. Power of two; DEPTH >= 2*INSTR_PER_FETCH.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- flush_i  in  1  redirect; discards all contents.
- fe_valid_i  in  1  fetch group valid.
- fe_ready_o  out  1  buffer can take a full group.
- fe_pc_i  in  VLEN  PC of lane 0.
- fe_instrs_i  in  INSTR_PER_FETCH*ILEN  lane k at bits [k*ILEN +: ILEN].
- fe_slot_valid_i  in  INSTR_PER_FETCH  per-lane valid; contiguous from bit 0.
- de_valid_o  out  DECODE_WIDTH  per-lane valid.
- de_instrs_o  out  DECODE_WIDTH*ILEN  oldest-first instructions.
- de_pc_o  out  DECODE_WIDTH*VLEN  matching PCs.
- de_ready_i  in  1  decode consumes all presented lanes.
- perf_full_stall_o  out  32  see Optional Feature.
- perf_empty_cyc_o  out  32  see Optional Feature.

Behaviour:
- Storage: circular array of {instr[ILEN], pc[VLEN]}.
  - Pointers head and tail, each clog2(DEPTH) bits; wrap is modulo DEPTH.
  - Occupancy count is clog2(DEPTH+1) bits.
- Reset: head=tail=count=0; fe_ready_o=1; de_valid_o=0; perf counters 0. Storage contents are not reset.
- fe_ready_o = (DEPTH - count) >= INSTR_PER_FETCH.
  - Driven from registered count only; no path from de_ready_i.
- Enqueue fires when fe_valid_i & fe_ready_o & !flush_i.
  - n_enq = number of leading ones in fe_slot_valid_i (0..INSTR_PER_FETCH).
  - Lane k is written to tail+k with pc = fe_pc_i + 4*k, truncated to VLEN.
  - tail advances by n_enq.
  - An all-zero mask is legal: handshake completes, nothing is stored.
  - A non-contiguous mask is a protocol error (assertion); only the leading ones are stored.
- Dequeue presentation:
  - n_pres = min(count, DECODE_WIDTH).
  - de_valid_o[k] = (k < n_pres) & !flush_i.
  - Lane k reads entry head+k with wrap.
  - Invalid lanes drive 0.
- Dequeue fires when de_ready_i & n_pres != 0 & !flush_i: all n_pres lanes are consumed and head advances by n_pres.
  - No partial acceptance.
- Enqueue and dequeue in the same cycle: count_next = count + n_enq - n_deq.
  - New entries never appear on de_* in the cycle they are written (latency = 1 cycle minimum).
- Flush:
  - flush_i high: the enqueue is dropped, de_valid_o=0, and next cycle head=tail=count=0.
  - fe_ready_o=1 the cycle after flush.
  - flush_i wins over any simultaneous handshake.
- Full: count > DEPTH-INSTR_PER_FETCH deasserts fe_ready_o even if dequeue happens the same cycle. Costs one bubble, by design.
- Empty: de_valid_o=0. fe_ready_o stays high.
- Reset mid-operation: asynchronous clear to the reset state; in-flight data is lost.

Optional Feature:
- Macro: INSTR_BUFFER_PERF_EN.
- Defined:
  - perf_full_stall_o counts cycles with fe_valid_i & !fe_ready_o & !flush_i.
  - perf_empty_cyc_o counts cycles with count==0.
  - Both are 32-bit saturating counters, reset to 0, not cleared by flush.
- Undefined: both outputs are tied to 0 and no counter flops are instantiated.

Decomposition:
- config_pkg:
  - Add DECODE_WIDTH and IBUF_DEPTH fields to user_cfg_t and cfg_t; the module parameters default from them.
  - Add localparam INSTR_BYTES = 4.
- Entry struct: typedef'd locally in the module, because it depends on Cfg widths.
- Sub-module: lead_ones_cnt, parameterised width, counting leading ones of a mask. Reusable by the ICache line splitter.

Test Plan (INSTR_PER_FETCH=4, DECODE_WIDTH=4, DEPTH=16):
- Reset released, one group at pc 0x8000_0000 with mask 1111 and instrs A,B,C,D, de_ready_i=1:
  - Next cycle de_valid_o=1111 with PCs 0x8000_0000/04/08/0C.
  - The following cycle de_valid_o=0000.
- de_ready_i=0 with four full groups:
  - count=16, fe_ready_o=0 after the 4th group.
  - The 5th group is held (fe_valid_i stays high).
  - After one dequeue, count=12 and fe_ready_o=1.
- Mask 0011, then mask 0111, with de_ready_i=0:
  - count=5.
  - de_* shows lanes 0-3 = first group lanes 0,1 then second group lanes 0,1; PCs are correct per group.
- Wrap: repeated enqueue/dequeue of 3-instruction groups for 20 cycles. Order and PCs are preserved across the head/tail wrap at index 15→0.
- flush_i with count=9 and simultaneous fe_valid_i:
  - de_valid_o=0 that cycle.
  - Next cycle count=0 and fe_ready_o=1; the dropped group never appears.
- INSTR_BUFFER_PERF_EN defined, 3 stalled cycles while full: perf_full_stall_o=3. Without the macro it stays 0.
